aes_key_schedule_gen: RTL

Parametrised AES key-schedule generator supporting AES-128, AES-192 and AES-256, selected per operation.
- Expands the master key one 32-bit word per cycle into an internal word store of up to 60 words.
- Streams round keys in forward order over a valid/ready handshake with backpressure.
- Offers a random-access round-key read port so the decrypt datapath can walk keys in reverse.
- Sits between the key-load interface and the AES round datapath (encrypt and decrypt).

---
 rtl/aes_ks_pkg.sv | 67 ++++++
 rtl/aes_key_schedule_gen_if.sv | 32 +++
 rtl/aes_sbox_word.sv | 10 +
 rtl/aes_key_schedule_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aes_ks_pkg.sv
// rtl/aes_ks_pkg.sv - key_len encodings, Nk/Nr lookup, Rcon and S-box helpers for the key schedule
package aes_ks_pkg;

    localparam logic [1:0] KL_128 = 2'd0;
    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;
    localparam logic [1:0] KL_BAD = 2'd3;
    localparam int         MAX_WORDS = 60;

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_HOLD} ks_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return nk_of(kl) + 4'd6;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse computed as x^254 (x^2 * x^4 * ... * x^128), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_schedule_gen_if.sv
// rtl/aes_key_schedule_gen_if.sv - key-load, round-key stream and random read bundle
interface aes_key_schedule_gen_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_ready;
    logic         err;
    logic [3:0]   nr;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         rd_err;

    modport master (
        output start, key_len, key_in, rk_ready, rd_en, rd_round,
        input  busy, done, keys_ready, err, nr, rk_valid, rk_round, rk_data,
               rd_valid, rd_data, rd_err
    );

    modport slave (
        input  start, key_len, key_in, rk_ready, rd_en, rd_round,
        output busy, done, keys_ready, err, nr, rk_valid, rk_round, rk_data,
               rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/aes_sbox_word.sv
// rtl/aes_sbox_word.sv - four parallel AES S-box lookups on a 32-bit word
module aes_sbox_word
    import aes_ks_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};
endmodule

// File: rtl/aes_key_schedule_gen.sv
// rtl/aes_key_schedule_gen.sv - AES-128/192/256 key expansion, one word per cycle,
// with a forward round-key stream and a random-access round-key read port
module aes_key_schedule_gen
    import aes_ks_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int DEBUG  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_key_schedule_gen_if.slave  bus
);
    ks_state_t    r_state;
    logic [31:0]  r_w [0:MAX_WORDS-1];
    logic [5:0]   r_idx;
    logic [5:0]   r_total;
    logic [3:0]   r_nk;
    logic [3:0]   r_nr;
    logic [3:0]   r_pos;
    logic [3:0]   r_rc;
    logic [3:0]   r_rk_ptr;
    logic         r_rk_live;
    logic         r_busy;
    logic         r_done;
    logic         r_keys_ready;
    logic         r_err;
    logic         r_rd_valid;
    logic         r_rd_err;
    logic [127:0] r_rd_data;

    logic [3:0]   w_nk_new;
    logic [3:0]   w_nr_new;
    logic         w_legal;
    logic         w_start_ok;
    logic         w_start_bad;
    logic [31:0]  w_prev;
    logic [31:0]  w_sb_in;
    logic [31:0]  w_sb_out;
    logic [31:0]  w_mix;
    logic [31:0]  w_new;
    logic [6:0]   w_rk_need;
    logic         w_rk_valid;
    logic [127:0] w_rk_word;
    logic [6:0]   w_rd_need;
    logic         w_rd_bad;
    logic [127:0] w_rd_word;

    assign w_nk_new    = nk_of(bus.key_len);
    assign w_nr_new    = nr_of(bus.key_len);
    assign w_legal     = (bus.key_len != KL_BAD) && (w_nk_new <= 4'(MAX_NK));
    assign w_start_ok  = bus.start && !r_busy && w_legal;
    assign w_start_bad = bus.start && !r_busy && !w_legal;

    // r_pos tracks i mod Nk and r_rc tracks i/Nk, so no divider is needed.
    assign w_prev  = r_w[r_idx - 6'd1];
    assign w_sb_in = (r_pos == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sbox_word u_sbox (
        .i_word (w_sb_in),
        .o_word (w_sb_out)
    );

    always_comb begin
        w_mix = w_prev;
        if (r_pos == 4'd0)
            w_mix = w_sb_out ^ {rcon(r_rc), 24'h0};
        else if (r_nk == 4'd8 && r_pos == 4'd4)
            w_mix = w_sb_out;
    end

    assign w_new = r_w[r_idx - {2'b00, r_nk}] ^ w_mix;

    // A round is readable once its last word (4r+3) is in the store.
    assign w_rk_need  = {1'b0, r_rk_ptr, 2'b00} + 7'd4;
    assign w_rk_valid = r_rk_live && ({1'b0, r_idx} >= w_rk_need);
    assign w_rk_word  = {r_w[{r_rk_ptr, 2'b00}], r_w[{r_rk_ptr, 2'b01}],
                         r_w[{r_rk_ptr, 2'b10}], r_w[{r_rk_ptr, 2'b11}]};

    assign w_rd_need = {1'b0, bus.rd_round, 2'b00} + 7'd4;
    assign w_rd_bad  = (bus.rd_round > r_nr) || ({1'b0, r_idx} < w_rd_need);
    assign w_rd_word = {r_w[{bus.rd_round, 2'b00}], r_w[{bus.rd_round, 2'b01}],
                        r_w[{bus.rd_round, 2'b10}], r_w[{bus.rd_round, 2'b11}]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            for (int j = 0; j < MAX_WORDS; j++) r_w[j] <= '0;
            r_idx        <= '0;
            r_total      <= '0;
            r_nk         <= '0;
            r_nr         <= '0;
            r_pos        <= '0;
            r_rc         <= '0;
            r_rk_ptr     <= '0;
            r_rk_live    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_ready <= 1'b0;
            r_err        <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_err     <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= bus.rd_en;
            r_rd_err   <= bus.rd_en && w_rd_bad;
            r_rd_data  <= (bus.rd_en && !w_rd_bad) ? w_rd_word : '0;

            if (w_rk_valid && bus.rk_ready) begin
                if (r_rk_ptr == r_nr) r_rk_live <= 1'b0;
                else                  r_rk_ptr  <= r_rk_ptr + 4'd1;
            end

            case (r_state)
                ST_EXPAND: begin
                    r_w[r_idx] <= w_new;
                    r_idx      <= r_idx + 6'd1;
                    if (r_pos == r_nk - 4'd1) begin
                        r_pos <= 4'd0;
                        r_rc  <= r_rc + 4'd1;
                    end else begin
                        r_pos <= r_pos + 4'd1;
                    end
                    if (r_idx == r_total - 6'd1) r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_busy) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_keys_ready <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Only reachable from IDLE or a settled HOLD, so it overrides the case above.
            if (w_start_ok) begin
                for (int j = 0; j < 8; j++)
                    if (4'(j) < w_nk_new) r_w[j] <= bus.key_in[255 - 32*j -: 32];
                r_state      <= ST_EXPAND;
                r_nk         <= w_nk_new;
                r_nr         <= w_nr_new;
                r_total      <= {w_nr_new + 4'd1, 2'b00};
                r_idx        <= {2'b00, w_nk_new};
                r_pos        <= 4'd0;
                r_rc         <= 4'd1;
                r_busy       <= 1'b1;
                r_keys_ready <= 1'b0;
                r_rk_ptr     <= 4'd0;
                r_rk_live    <= 1'b1;
            end else if (w_start_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    generate
        if (DEBUG != 0) begin : g_trace
            logic [31:0] w_trace_word_unused;
            assign w_trace_word_unused = w_new;
        end
    endgenerate

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.keys_ready = r_keys_ready;
    assign bus.err        = r_err;
    assign bus.nr         = r_nr;
    assign bus.rk_valid   = w_rk_valid;
    assign bus.rk_round   = r_rk_ptr;
    assign bus.rk_data    = w_rk_valid ? w_rk_word : '0;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_err     = r_rd_err;
    assign bus.rd_data    = r_rd_data;
endmodule
